// File: rtl/mandel_iter_core_if.sv
// rtl/mandel_iter_core_if.sv - point request / result handshake bundle for mandel_iter_core
interface mandel_iter_core_if #(
   parameter int WIDTH  = 32,
   parameter int ITER_W = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [WIDTH-1:0]  c_re;
   logic signed [WIDTH-1:0]  c_im;
   logic                     out_valid;
   logic                     out_ready;
   logic [ITER_W-1:0]        out_iter;
   logic                     busy;

   modport master (
      output in_valid, c_re, c_im, out_ready,
      input  in_ready, out_valid, out_iter, busy
   );

   modport slave (
      input  in_valid, c_re, c_im, out_ready,
      output in_ready, out_valid, out_iter, busy
   );
endinterface

// File: rtl/mandel_iter_core.sv
// rtl/mandel_iter_core.sv - Mandelbrot escape-time engine, one point at a time
// Optional main-cardioid precheck enabled by MANDEL_CARDIOID_EN.
module mandel_iter_core #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 28,
   parameter int ITER_W   = 8,
   parameter int MAX_ITER = 255
) (
   input  logic clock,
   input  logic reset,
   mandel_iter_core_if.slave bus
);

`ifdef MANDEL_CARDIOID_EN
   typedef enum logic [2:0] {IDLE, MULT, CHECK, ADD, DONE, PRE_MULT, PRE_CHECK} state_t;
`else
   typedef enum logic [2:0] {IDLE, MULT, CHECK, ADD, DONE} state_t;
`endif

   localparam int PW = 2 * WIDTH;

   // 4.0 expressed in the Q(2*FRAC) scale of the squared magnitude
   localparam logic signed [PW:0] ESC_LIMIT =
      {{(PW - 2*FRAC - 2){1'b0}}, 1'b1, {(2*FRAC + 2){1'b0}}};

   state_t                   state;
   logic signed [WIDTH-1:0]  zr, zi, cr, ci;
   logic [ITER_W-1:0]        iter;
   logic [ITER_W-1:0]        result;
   logic signed [PW-1:0]     zr2, zi2, zri;
   logic                     in_ready_q, out_valid_q, busy_q;

   logic signed [PW-1:0]     zr_ext, zi_ext;
   logic signed [PW:0]       esc_sum, diff;
   logic                     escaped;

   assign zr_ext  = {{WIDTH{zr[WIDTH-1]}}, zr};
   assign zi_ext  = {{WIDTH{zi[WIDTH-1]}}, zi};
   assign esc_sum = {zr2[PW-1], zr2} + {zi2[PW-1], zi2};
   assign diff    = {zr2[PW-1], zr2} - {zi2[PW-1], zi2};
   assign escaped = esc_sum > ESC_LIMIT;

`ifdef MANDEL_CARDIOID_EN
   localparam int XW = WIDTH + 1;
   localparam int QW = 2 * XW + 1;
   localparam int LW = 2 * (QW + 1);
   localparam logic signed [XW-1:0] QUARTER =
      {{(XW - FRAC + 1){1'b0}}, 1'b1, {(FRAC - 2){1'b0}}};

   logic signed [XW-1:0]     x_val;
   logic signed [2*XW-1:0]   x_ext, ci_ext, x2, ci2;
   logic signed [QW-1:0]     q_full, q;
   logic signed [QW:0]       qx;
   logic signed [LW-1:0]     lhs, rhs;
   logic                     inside;

   // x gets one extra bit so cr near the negative limit cannot wrap
   assign x_val  = {cr[WIDTH-1], cr} - QUARTER;
   assign x_ext  = {{XW{x_val[XW-1]}}, x_val};
   assign ci_ext = {{(2*XW-WIDTH){ci[WIDTH-1]}}, ci};
   assign q_full = {x2[2*XW-1], x2} + {ci2[2*XW-1], ci2};
   assign q      = q_full >>> FRAC;
   assign qx     = {q[QW-1], q} + {{(QW+1-XW){x_val[XW-1]}}, x_val};
   assign lhs    = {{(LW-QW){q[QW-1]}}, q} * {{(LW-QW-1){qx[QW]}}, qx};
   assign rhs    = {{(LW-2*XW){ci2[2*XW-1]}}, ci2} >>> 2;
   assign inside = lhs <= rhs;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         zr          <= '0;
         zi          <= '0;
         cr          <= '0;
         ci          <= '0;
         iter        <= '0;
         result      <= '0;
         zr2         <= '0;
         zi2         <= '0;
         zri         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef MANDEL_CARDIOID_EN
         x2          <= '0;
         ci2         <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  cr         <= bus.c_re;
                  ci         <= bus.c_im;
                  zr         <= '0;
                  zi         <= '0;
                  iter       <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef MANDEL_CARDIOID_EN
                  state      <= PRE_MULT;
`else
                  state      <= MULT;
`endif
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
`ifdef MANDEL_CARDIOID_EN
            PRE_MULT: begin
               x2    <= x_ext * x_ext;
               ci2   <= ci_ext * ci_ext;
               state <= PRE_CHECK;
            end
            PRE_CHECK: begin
               if (inside) begin
                  result <= ITER_W'(MAX_ITER);
                  state  <= DONE;
               end else begin
                  state  <= MULT;
               end
            end
`endif
            MULT: begin
               zr2   <= zr_ext * zr_ext;
               zi2   <= zi_ext * zi_ext;
               zri   <= zr_ext * zi_ext;
               state <= CHECK;
            end
            CHECK: begin
               if (escaped) begin
                  result <= iter;
                  state  <= DONE;
               end else if (iter == ITER_W'(MAX_ITER)) begin
                  result <= ITER_W'(MAX_ITER);
                  state  <= DONE;
               end else begin
                  state  <= ADD;
               end
            end
            ADD: begin
               // 2*zr*zi comes from shifting one bit less than FRAC
               zr    <= WIDTH'(diff >>> FRAC) + cr;
               zi    <= WIDTH'(zri >>> (FRAC - 1)) + ci;
               iter  <= iter + 1'b1;
               state <= MULT;
            end
            DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_iter  = result;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mandel_iter_core.sv
// tb/tb_mandel_iter_core.sv - directed-vector bench for mandel_iter_core
module tb_mandel_iter_core;

   localparam logic [31:0] Q_ZERO  = 32'h0000_0000;
   localparam logic [31:0] Q_TWO   = 32'h2000_0000;
   localparam logic [31:0] Q_THREE = 32'h3000_0000;
   localparam logic [31:0] Q_MTWO  = 32'hE000_0000;

`ifdef MANDEL_CARDIOID_EN
   localparam int PRE        = 2;
   localparam int ORIGIN_LAT = 3;
`else
   localparam int PRE        = 0;
   localparam int ORIGIN_LAT = 768;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mandel_iter_core_if #(.WIDTH(32), .ITER_W(8)) bus ();

   mandel_iter_core #(
      .WIDTH(32), .FRAC(28), .ITER_W(8), .MAX_ITER(255)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   task automatic send_point(input logic [31:0] re, input logic [31:0] im);
      int guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      bus.c_re     = re;
      bus.c_im     = im;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!bus.out_valid && lat < 2000);
   endtask

   task automatic release_result();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.c_re = '0;
      bus.c_im = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
      total++; if (bus.out_iter !== 8'd0) begin bad++; $display("FAIL reset_out_iter got=%0d want=0", bus.out_iter); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%0b want=1", bus.in_ready); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b want=0", bus.busy); end
   endtask

   task automatic test_point(input string name, input logic [31:0] re, input logic [31:0] im,
                             input int exp_iter, input int exp_lat);
      int lat;
      send_point(re, im);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%0b want=1", name, bus.busy); end
      wait_valid(lat);
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat); end
      total++; if (bus.out_iter !== 8'(exp_iter)) begin bad++; $display("FAIL %s_iter got=%0d want=%0d", name, bus.out_iter, exp_iter); end
      release_result();
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL %s_release got valid=%0b ready=%0b want valid=0 ready=1", name, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_origin();
      test_point("origin", Q_ZERO, Q_ZERO, 255, ORIGIN_LAT);
   endtask

   task automatic test_fast_escape();
      test_point("fast_escape", Q_THREE, Q_ZERO, 1, 6 + PRE);
   endtask

   task automatic test_threshold();
      test_point("threshold", Q_TWO, Q_ZERO, 2, 9 + PRE);
   endtask

   task automatic test_neg_two();
      test_point("neg_two", Q_MTWO, Q_ZERO, 255, 768 + PRE);
   endtask

   task automatic test_backpressure();
      int lat;
      send_point(Q_THREE, Q_ZERO);
      // a competing request for the origin must stay unsampled while busy
      bus.c_re     = Q_ZERO;
      bus.c_im     = Q_ZERO;
      bus.in_valid = 1'b1;
      wait_valid(lat);
      total++; if (lat !== 6 + PRE) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, 6 + PRE); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_iter !== 8'd1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle=%0d got valid=%0b iter=%0d ready=%0b want 1/1/0",
                     i, bus.out_valid, bus.out_iter, bus.in_ready);
         end
      end
      bus.in_valid = 1'b0;
      release_result();
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept busy got=%0b want=0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      send_point(Q_ZERO, Q_ZERO);
      repeat (2 + PRE) @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%0b want=1", bus.busy); end
      rst = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_iter !== 8'd0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_outputs got ready=%0b valid=%0b iter=%0d busy=%0b want all 0",
                  bus.in_ready, bus.out_valid, bus.out_iter, bus.busy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL mid_no_result got valid=%0b busy=%0b want 0/0", bus.out_valid, bus.busy);
      end
      test_point("after_reset", Q_THREE, Q_ZERO, 1, 6 + PRE);
   endtask

   initial begin
      test_reset();
      test_origin();
      test_fast_escape();
      test_threshold();
      test_neg_two();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
